// File: rtl/board_lock_module.sv
// board_lock_module: playfield store and piece-lock engine.
// A landed piece (four 4-bit row bitmaps plus a board position) is ORed into
// the board over four WRITE cycles. A COMPACT sweep then copies non-full rows
// downward, and FILL zeroes the rows vacated at the top.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, clear_board  lock request / board wipe, sampled only when idle
//   piece_x, piece_y    board column of bitmap bit 0, board row of pixels0
//   pixels0..pixels3    piece rows, bit c = column offset c
//   rd_row, rd_data     combinational renderer read port (0 beyond the board)
//   busy, done          lock in progress / one-cycle completion pulse
//   lines_cleared       rows removed by the last lock
//   out_of_bounds       last lock dropped at least one set pixel
module board_lock_module #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear_board,
    input  logic [3:0]         piece_x,
    input  logic [4:0]         piece_y,
    input  logic [3:0]         pixels0,
    input  logic [3:0]         pixels1,
    input  logic [3:0]         pixels2,
    input  logic [3:0]         pixels3,
    input  logic [4:0]         rd_row,
    output logic [BOARD_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic [2:0]         lines_cleared,
    output logic               out_of_bounds
);

    // Wide enough for a 4-bit row shifted by up to 15 columns.
    localparam int unsigned ShW = BOARD_W + 19;

    typedef enum logic [2:0] {StIdle, StWrite, StCompact, StFill, StDone} state_e;

    state_e             state_q;
    logic [BOARD_W-1:0] board_q [BOARD_H];
    logic [3:0]         pix_q [4];
    logic [3:0]         px_q;
    logic [4:0]         py_q;
    logic [1:0]         wr_r_q;
    logic [4:0]         src_q;
    logic [4:0]         dst_q;
    logic [2:0]         k_q;
    logic               oob_q;

    // Write-path decode for the current WRITE row.
    logic [3:0]         pix_sel;
    logic [5:0]         wr_row;
    logic               row_ok;
    logic [ShW-1:0]     wide;
    logic [BOARD_W-1:0] wr_bits;
    logic               wr_oob;
    logic               src_full;

    always_comb begin
        pix_sel  = pix_q[wr_r_q];
        wr_row   = {1'b0, py_q} + {4'b0000, wr_r_q};
        row_ok   = wr_row < 6'(BOARD_H);
        wide     = {{(ShW-4){1'b0}}, pix_sel} << px_q;
        wr_bits  = wide[BOARD_W-1:0];
        // Any set pixel that misses the board in either direction is dropped.
        wr_oob   = (pix_sel != 4'b0000) && (!row_ok || (|wide[ShW-1:BOARD_W]));
        src_full = &board_q[src_q];
    end

    always_comb begin
        rd_data = '0;
        if (rd_row < 5'(BOARD_H)) begin
            rd_data = board_q[rd_row];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            for (int i = 0; i < BOARD_H; i++) begin
                board_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                pix_q[i] <= '0;
            end
            px_q          <= '0;
            py_q          <= '0;
            wr_r_q        <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            k_q           <= '0;
            oob_q         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            out_of_bounds <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_board) begin
                        for (int i = 0; i < BOARD_H; i++) begin
                            board_q[i] <= '0;
                        end
                    end else if (start) begin
                        pix_q[0] <= pixels0;
                        pix_q[1] <= pixels1;
                        pix_q[2] <= pixels2;
                        pix_q[3] <= pixels3;
                        px_q     <= piece_x;
                        py_q     <= piece_y;
                        wr_r_q   <= '0;
                        oob_q    <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StWrite;
                    end
                end
                StWrite: begin
                    if (row_ok) begin
                        board_q[wr_row[4:0]] <= board_q[wr_row[4:0]] | wr_bits;
                    end
                    if (wr_oob) begin
                        oob_q <= 1'b1;
                    end
                    wr_r_q <= wr_r_q + 2'd1;
                    if (wr_r_q == 2'd3) begin
                        src_q   <= 5'(BOARD_H - 1);
                        dst_q   <= 5'(BOARD_H - 1);
                        k_q     <= '0;
                        state_q <= StCompact;
                    end
                end
                StCompact: begin
                    // dst never runs below src, so the copy target is always on the board.
                    if (src_full) begin
                        k_q <= k_q + 3'd1;
                    end else begin
                        board_q[dst_q] <= board_q[src_q];
                        dst_q          <= dst_q - 5'd1;
                    end
                    src_q <= src_q - 5'd1;
                    if (src_q == 5'd0) begin
                        if (src_full || (k_q != 3'd0)) begin
                            state_q <= StFill;
                        end else begin
                            done          <= 1'b1;
                            lines_cleared <= k_q;
                            out_of_bounds <= oob_q;
                            state_q       <= StDone;
                        end
                    end
                end
                StFill: begin
                    // dst enters at k-1, so stopping at row 0 gives exactly k cycles.
                    board_q[dst_q] <= '0;
                    dst_q          <= dst_q - 5'd1;
                    if (dst_q == 5'd0) begin
                        done          <= 1'b1;
                        lines_cleared <= k_q;
                        out_of_bounds <= oob_q;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
